// File: rtl/otp_array_model.sv
`timescale 1ns/1ps
// otp_array_model: A x B one-time-programmable fuse array with a timed program handshake and delayed sense.
// Optional feature: define OTP_PERSIST_EN to keep the fuse store across reset (cleared only at time zero).
module otp_array_model #(
  parameter int A           = 2,
  parameter int B           = 2,
  parameter int PROG_CYCLES = 4,
  parameter int READ_LAT    = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2*B-1:0] PL,
  input  logic [B-1:0]   BL,
  input  logic [A-1:0]   WLN,
  input  logic [A-1:0]   WLP,
  input  logic           PRG,
  output logic           writing_successful,
  output logic [A-1:0]   sense_data,
  output logic           sense_valid,
  output logic           fault
);

  typedef enum logic [2:0] {IDLE, PROG, BURN, ACK, SENSE, FAULT} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [B-1:0]        col_q, col_d;
  logic [A-1:0]        wlp_q, wlp_d;
  logic [A-1:0]        wln_q, wln_d;
  logic [A-1:0][B-1:0] fuse_d;
  logic [A-1:0]        sense_data_q, sense_data_d;
  logic                sense_valid_q, sense_valid_d;
  logic                ack_q, ack_d;
  logic                fault_q, fault_d;

  logic [2*B-1:0]      pl_expect;
  logic [A-1:0][B-1:0] burn_mask;
  logic [A-1:0]        sensed;
  logic                prog_legal;
  logic                prog_hold;

`ifdef OTP_PERSIST_EN
  logic [A-1:0][B-1:0] fuse_q = '0;
`else
  logic [A-1:0][B-1:0] fuse_q;
`endif

  // Column c must drive its PL pair to 2'b11; every other pair must be quiet.
  genvar gi, gj;
  generate
    for (gi = 0; gi < B; gi = gi + 1) begin : g_pl
      assign pl_expect[2*gi +: 2] = {2{BL[gi]}};
    end
    for (gi = 0; gi < A; gi = gi + 1) begin : g_row
      for (gj = 0; gj < B; gj = gj + 1) begin : g_col
        assign burn_mask[gi][gj] = wlp_q[gi] & col_q[gj];
      end
      assign sensed[gi] = wln_q[gi] & (|(fuse_q[gi] & col_q));
    end
  endgenerate

  assign prog_legal = PRG && $onehot(BL) && (PL == pl_expect);
  assign prog_hold  = prog_legal && (BL == col_q) && (WLP == wlp_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    col_d         = col_q;
    wlp_d         = wlp_q;
    wln_d         = wln_q;
    fuse_d        = fuse_q;
    sense_data_d  = sense_data_q;
    sense_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (PRG) begin
          if (prog_legal) begin
            state_d = PROG;
            cnt_d   = 8'd1;
            col_d   = BL;
            wlp_d   = WLP;
          end else begin
            state_d = FAULT;
          end
        end else if ($onehot(BL) && (|WLN)) begin
          state_d = SENSE;
          cnt_d   = 8'd1;
          col_d   = BL;
          wln_d   = WLN;
        end
      end
      // The entry edge already counts as the first qualifying edge.
      PROG: begin
        if (!prog_hold) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'(PROG_CYCLES - 1)) begin
          state_d = BURN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      BURN: begin
        fuse_d  = fuse_q | burn_mask;
        state_d = ACK;
      end
      ACK: begin
        if (!PRG) state_d = IDLE;
      end
      SENSE: begin
        if (PRG) begin
          state_d = FAULT;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'(READ_LAT)) begin
          state_d       = IDLE;
          cnt_d         = 8'd0;
          sense_data_d  = sensed;
          sense_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FAULT: begin
        if (!PRG && (BL == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ack_d   = (state_d == ACK);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      col_q         <= '0;
      wlp_q         <= '0;
      wln_q         <= '0;
      sense_data_q  <= '0;
      sense_valid_q <= 1'b0;
      ack_q         <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      wlp_q         <= wlp_d;
      wln_q         <= wln_d;
      sense_data_q  <= sense_data_d;
      sense_valid_q <= sense_valid_d;
      ack_q         <= ack_d;
      fault_q       <= fault_d;
    end
  end

  // While reset holds the FSM in IDLE, fuse_d equals fuse_q, so a persistent store cannot change.
`ifdef OTP_PERSIST_EN
  always_ff @(posedge clk) begin
    fuse_q <= fuse_d;
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fuse_q <= '0;
    else       fuse_q <= fuse_d;
  end
`endif

  assign writing_successful = ack_q;
  assign sense_data         = sense_data_q;
  assign sense_valid        = sense_valid_q;
  assign fault              = fault_q;

endmodule

// File: tb/tb_otp_array_model.sv
`timescale 1ns/1ps
// Directed testbench for otp_array_model (A=2, B=2, PROG_CYCLES=4, READ_LAT=2).
module tb_otp_array_model;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] PL;
  logic [1:0] BL;
  logic [1:0] WLN;
  logic [1:0] WLP;
  logic       PRG;
  logic       writing_successful;
  logic [1:0] sense_data;
  logic       sense_valid;
  logic       fault;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [1:0] last_sd   = 2'b00;

  always #5 clk = ~clk;

  otp_array_model #(
    .A(2), .B(2), .PROG_CYCLES(4), .READ_LAT(2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .PL                (PL),
    .BL                (BL),
    .WLN               (WLN),
    .WLP               (WLP),
    .PRG               (PRG),
    .writing_successful(writing_successful),
    .sense_data        (sense_data),
    .sense_valid       (sense_valid),
    .fault             (fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PRG = 1'b0; BL = 2'b00; PL = 4'b0000; WLN = 2'b00; WLP = 2'b00;
  endtask

  // Full program handshake; the ack must appear after the 5th edge (E0+4).
  task automatic do_burn(input logic [1:0] bl, input logic [3:0] pl, input logic [1:0] wlp, input string tag);
    int idx;
    idx = -1;
    PRG = 1'b1; BL = bl; PL = pl; WLP = wlp; WLN = 2'b00;
    for (int i = 0; i < 10 && idx < 0; i++) begin
      step();
      if (writing_successful === 1'b1) idx = i;
    end
    total_cnt++;
    if (idx != 4) $display("FAIL %s ack_latency: got %0d expected 4", tag, idx);
    else pass_cnt++;
    step();
    total_cnt++;
    if (writing_successful !== 1'b1) $display("FAIL %s ack_held: got %b expected 1", tag, writing_successful);
    else pass_cnt++;
    PRG = 1'b0;
    step();
    total_cnt++;
    if (writing_successful !== 1'b0) $display("FAIL %s ack_release: got %b expected 0", tag, writing_successful);
    else pass_cnt++;
    idle_inputs();
    $display("burn %s bl=%b wlp=%b ack_idx=%0d", tag, bl, wlp, idx);
  endtask

  // Sense of one column; sense_valid must pulse once after edge E0+2.
  task automatic do_read(input logic [1:0] bl, input logic [1:0] wln, input logic [1:0] exp, input string tag);
    int idx;
    int pulses;
    logic [1:0] got;
    idx = -1; pulses = 0; got = 2'bxx;
    PRG = 1'b0; BL = bl; WLN = wln; PL = 4'b0000; WLP = 2'b00;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) begin BL = 2'b00; WLN = 2'b00; end
      if (sense_valid === 1'b1) begin
        pulses++;
        if (idx < 0) begin idx = i; got = sense_data; end
      end
    end
    total_cnt++;
    if (pulses != 1) $display("FAIL %s valid_pulses: got %0d expected 1", tag, pulses);
    else pass_cnt++;
    total_cnt++;
    if (idx != 2) $display("FAIL %s valid_latency: got %0d expected 2", tag, idx);
    else pass_cnt++;
    total_cnt++;
    if (got !== exp) $display("FAIL %s sense_data: got %b expected %b", tag, got, exp);
    else pass_cnt++;
    total_cnt++;
    if (sense_data !== exp) $display("FAIL %s sense_hold: got %b expected %b", tag, sense_data, exp);
    else pass_cnt++;
    last_sd = exp;
    $display("read %s bl=%b wln=%b data=%b idx=%0d", tag, bl, wln, got, idx);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    total_cnt++;
    if ({writing_successful, sense_valid, fault, sense_data} !== 5'b0)
      $display("FAIL reset_outputs: got %b expected 00000", {writing_successful, sense_valid, fault, sense_data});
    else pass_cnt++;
    reset = 1'b0;
    step();
    total_cnt++;
    if ({writing_successful, sense_valid, fault} !== 3'b0)
      $display("FAIL post_reset_idle: got %b expected 000", {writing_successful, sense_valid, fault});
    else pass_cnt++;
    $display("reset done");
  endtask

  task automatic test_reset_mid_prog();
    // Reset after two PROG edges.
    PRG = 1'b1; BL = 2'b10; PL = 4'b1100; WLP = 2'b11;
    step(); step();
    reset = 1'b1;
    #1;
    total_cnt++;
    if (writing_successful !== 1'b0) $display("FAIL mid_prog_reset_ack: got %b expected 0", writing_successful);
    else pass_cnt++;
    idle_inputs();
    step();
    reset = 1'b0;
    step();
    // Reset while sitting in BURN, before the burning edge.
    PRG = 1'b1; BL = 2'b10; PL = 4'b1100; WLP = 2'b11;
    step(); step(); step(); step();
    total_cnt++;
    if (writing_successful !== 1'b0) $display("FAIL burn_state_no_ack: got %b expected 0", writing_successful);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    idle_inputs();
    step();
    reset = 1'b0;
    step();
    do_read(2'b10, 2'b11, 2'b00, "mid_prog_read_c1");
  endtask

  task automatic test_burn();
    do_burn(2'b01, 4'b0011, 2'b10, "burn_c0r1");
    do_read(2'b01, 2'b11, 2'b10, "read_c0");
  endtask

  task automatic test_abort();
    bit seen;
    seen = 1'b0;
    PRG = 1'b1; BL = 2'b10; PL = 4'b1100; WLP = 2'b10;
    step(); step();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      step();
      if (writing_successful !== 1'b0) seen = 1'b1;
    end
    total_cnt++;
    if (seen) $display("FAIL abort_no_ack: got ack expected none");
    else pass_cnt++;
    $display("abort after 2 edges ack_seen=%0d", seen);
    do_read(2'b10, 2'b11, 2'b00, "abort_read_c1");
    do_read(2'b01, 2'b11, 2'b10, "abort_read_c0");
  endtask

  task automatic test_wlp_zero();
    do_burn(2'b01, 4'b0011, 2'b00, "burn_wlp0");
    do_read(2'b01, 2'b11, 2'b10, "wlp0_read_c0");
  endtask

  task automatic test_monotonic();
    do_burn(2'b10, 4'b1100, 2'b01, "burn_c1r0");
    do_read(2'b10, 2'b11, 2'b01, "mono_read1");
    do_burn(2'b10, 4'b1100, 2'b10, "burn_c1r1");
    do_read(2'b10, 2'b11, 2'b11, "mono_read2");
    do_read(2'b10, 2'b01, 2'b01, "wln_mask");
  endtask

  task automatic test_illegal();
    PRG = 1'b1; BL = 2'b11; PL = 4'b0000;
    step();
    total_cnt++;
    if (fault !== 1'b1) $display("FAIL bl_two_hot_fault: got %b expected 1", fault);
    else pass_cnt++;
    PRG = 1'b0; BL = 2'b01;
    step();
    total_cnt++;
    if (fault !== 1'b1) $display("FAIL fault_sticky_bl: got %b expected 1", fault);
    else pass_cnt++;
    BL = 2'b00;
    step();
    total_cnt++;
    if (fault !== 1'b0) $display("FAIL fault_release: got %b expected 0", fault);
    else pass_cnt++;
    $display("illegal two-hot BL handled");

    PRG = 1'b1; BL = 2'b01; PL = 4'b0111;
    step();
    total_cnt++;
    if (fault !== 1'b1) $display("FAIL bad_pl_fault: got %b expected 1", fault);
    else pass_cnt++;
    idle_inputs();
    step();
    total_cnt++;
    if (fault !== 1'b0) $display("FAIL bad_pl_release: got %b expected 0", fault);
    else pass_cnt++;
    $display("illegal PL handled");

    // PRG raised during a sense: fault, no strobe, data untouched.
    PRG = 1'b0; BL = 2'b01; WLN = 2'b11;
    step();
    PRG = 1'b1; BL = 2'b00; WLN = 2'b00;
    step();
    total_cnt++;
    if ({fault, sense_valid, sense_data} !== {1'b1, 1'b0, last_sd})
      $display("FAIL sense_abort: got %b expected %b", {fault, sense_valid, sense_data}, {1'b1, 1'b0, last_sd});
    else pass_cnt++;
    idle_inputs();
    step();
    total_cnt++;
    if ({fault, sense_valid} !== 2'b00) $display("FAIL sense_abort_release: got %b expected 00", {fault, sense_valid});
    else pass_cnt++;
    $display("sense aborted by PRG");
    do_read(2'b01, 2'b11, 2'b10, "post_fault_read_c0");
  endtask

  task automatic test_persist();
    logic [1:0] exp_c0;
    logic [1:0] exp_c1;
`ifdef OTP_PERSIST_EN
    exp_c0 = 2'b11;
    exp_c1 = 2'b11;
`else
    exp_c0 = 2'b00;
    exp_c1 = 2'b00;
`endif
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({writing_successful, sense_valid, fault, sense_data} !== 5'b0)
      $display("FAIL async_reset_outputs: got %b expected 00000", {writing_successful, sense_valid, fault, sense_data});
    else pass_cnt++;
    step();
    reset = 1'b0;
    step();
    do_burn(2'b01, 4'b0011, 2'b01, "burn_c0r0");
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    do_read(2'b01, 2'b11, exp_c0, "persist_read_c0");
    do_read(2'b10, 2'b11, exp_c1, "persist_read_c1");
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_reset_mid_prog();
    test_burn();
    test_abort();
    test_wlp_zero();
    test_monotonic();
    test_illegal();
    test_persist();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/otp_array_model.md
OTP_ARRAY_MODEL -- requirements
Module: otp_array_model

Interface
REQ-001 Parameter A, default 2: number of rows (word lines).
REQ-002 Parameter B, default 2: number of columns (bit lines).
REQ-003 Parameter PROG_CYCLES, default 4, legal range 2..255: consecutive sampled edges required to burn.
REQ-004 Parameter READ_LAT, default 2, legal range 1..255: sense latency in cycles.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 PL  input  2*B  program-line pair per column; column c owns PL[2c+1:2c].
REQ-008 BL  input  B  bit-line column select; exactly one bit set (one-hot) when legal.
REQ-009 WLN  input  A  read word-line row mask.
REQ-010 WLP  input  A  program word-line row mask.
REQ-011 PRG  input  1  program-mode strobe.
REQ-012 writing_successful  output  1  burn acknowledge.
REQ-013 sense_data  output  A  sensed bits of the selected column.
REQ-014 sense_valid  output  1  one-cycle strobe; sense_data is updated in the same cycle.
REQ-015 fault  output  1  illegal drive detected.

Function
REQ-016 The block SHALL hold an A x B fuse store; a fuse bit only transitions 0->1, never 1->0, outside reset.
REQ-017 The FSM SHALL have exactly the states IDLE, PROG, BURN, ACK, SENSE and FAULT.
REQ-018 A program request is legal when PRG=1, BL is one-hot with column c, PL[2c+1:2c]=2'b11 and all other PL bits are 0.
REQ-019 In IDLE:
- A legal program request SHALL go to PROG and latch c and WLP; this edge is E0.
- PRG=1 without a legal request SHALL go to FAULT.
- Otherwise, PRG=0 with one-hot BL and nonzero WLN SHALL go to SENSE and latch the column and WLN; this edge is E0.
REQ-020 In PROG:
- PRG, PL, BL and WLP sampled equal to the latched values SHALL advance the count.
- After PROG_CYCLES consecutive qualifying edges, counting E0, the FSM SHALL go to BURN.
- Any deviation SHALL abort to IDLE with the fuse store unchanged.
REQ-021 BURN SHALL OR the latched WLP mask into column c, then go to ACK on the next edge.
REQ-022 writing_successful SHALL be 1 only in ACK: first high after edge E0+PROG_CYCLES, held until PRG is sampled 0, then the FSM returns to IDLE.
REQ-023 SENSE:
- At edge E0+READ_LAT, sense_data SHALL load fuse[r][col] AND latched WLN[r] for every row r.
- sense_valid SHALL pulse high for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-024 sense_data SHALL hold its value between sense operations.
REQ-025 PRG=1 sampled in SENSE SHALL go to FAULT, with no sense_valid pulse and sense_data unchanged.
REQ-026 fault SHALL be 1 only in FAULT; the FSM leaves FAULT for IDLE when PRG=0 and BL=0 are sampled together.
REQ-027 A WLP of all zeros in a legal request SHALL complete the handshake with no fuse change.

Reset
REQ-028 reset SHALL immediately force IDLE and set writing_successful=0, sense_valid=0, fault=0, sense_data=0, and counters and latches to 0.
REQ-029 Reset asserted in PROG or BURN before the BURN edge SHALL leave the fuse store unmodified.

Configuration
REQ-030 Macro OTP_PERSIST_EN:
- Defined: the fuse store SHALL be excluded from reset and retain its contents across reset, initialised to 0 only at time zero.
- Undefined: reset SHALL clear the fuse store to all 0.

Verification
REQ-031 Setup for all scenarios: A=2, B=2, PROG_CYCLES=4, READ_LAT=2.
REQ-032 Burn: PRG=1, BL=2'b01, PL=4'b0011, WLP=2'b10 held until ack -> writing_successful high 4 edges after E0; a subsequent read with BL=01, WLN=11 -> sense_data=2'b10 with sense_valid high one cycle, 2 edges after E0.
REQ-033 Abort: the same request with PRG dropped after 2 edges -> writing_successful never rises; read -> sense_data=2'b00.
REQ-034 Illegal drive: PRG=1, BL=2'b11 -> fault=1 next cycle; PRG=0 with BL=0 -> fault=0 and state IDLE.
REQ-035 Monotonic fuse: burn row 0 of column 1, then burn row 1 of column 1 -> read of column 1 with WLN=11 returns 2'b11.
REQ-036 Reset and macro: burn column 0 row 0, pulse reset, read -> 2'b01 with OTP_PERSIST_EN defined, 2'b00 without; reset mid-PROG -> column unchanged.
